risc8_system: RTL and testbench
===============================

Name: risc8_system

Overview:
- Self-contained 8-bit accumulator RISC processor with its program ROM and data RAM on a shared 13-bit address / 8-bit data bus.
- Each instruction is 16 bits, stored as two ROM bytes (high byte first): opcode = bits[15:13], operand address = bits[12:0].
- Every instruction takes exactly 8 clk cycles.
- Used as the top-level CPU block for diagnostic and Fibonacci programs that are preloaded into ROM and RAM.

Parameters:
none (address width 13, data width 8, ROM 8192x8 and RAM 1024x8 are fixed)

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high reset
halt  output  1  high once an HLT instruction has been decoded
rd  output  1  bus read strobe
wr  output  1  bus write strobe
addr  output  13  current bus address
data  output  8  current shared data-bus value (Z when undriven)
opcode  output  3  IR[15:13]
fetch  output  1  high during the fetch half (states 0-3) of each instruction
ir_addr  output  13  IR[12:0]
pc_addr  output  13  program counter

Behaviour:
- Reset (synchronous, clk rising edge with reset=1):
  - pc=0, acc=0, IR=0, state=S0, halt=0.
  - rd=0, wr=0, CPU data driver off. ROM/RAM contents unchanged.
- Address mux: addr = fetch ? pc_addr : ir_addr.
- Address decode:
  - addr[12:11]==2'b11 selects RAM, indexed by addr[9:0]; the 1K RAM aliases twice over 0x1800-0x1FFF.
  - All other addresses select ROM.
- Memories:
  - ROM array is named memory; RAM array is named ram. Both are preloadable by $readmemb.
  - Reads are combinational: the selected memory drives the bus when rd=1.
  - RAM writes happen on the rising clk edge when wr=1 and RAM is selected.
  - Writes to ROM addresses are ignored.
  - Exactly one driver is active on the bus at a time.
- 8-state controller, S0->S7->S0, one state per clk:
  - S0: rd=1. End of cycle: IR[15:8]<=data, pc<=pc+1.
  - S1: rd=1. End of cycle: IR[7:0]<=data, pc<=pc+1. pc is odd here with fetch=1.
  - S2: idle.
  - S3: if opcode==HLT, halt<=1 and the state freezes in S3 (pc, acc, IR held) until reset.
  - S4: if ADD/AND/XOR/LDA, rd=1. If JMP, pc<=ir_addr at end of cycle.
  - S5:
    - ADD/AND/XOR/LDA: rd=1, acc<=ALU(acc, data) at end of cycle.
    - STO: CPU drives acc onto the bus.
  - S6:
    - STO: CPU drives acc and wr=1; RAM captures on the edge.
    - SKZ with acc==0: pc<=pc+2, skipping the next instruction.
  - S7: idle; next state is S0.
- Opcodes:
  - 0 HLT
  - 1 SKZ: skip next instruction if acc==0
  - 2 ADD: acc=acc+M, 8-bit wrap, no carry
  - 3 AND: acc=acc&M
  - 4 XOR: acc=acc^M
  - 5 LDA: acc=M
  - 6 STO: M=acc
  - 7 JMP: pc=ir_addr
- Zero test uses acc as it stands at the start of S6.
- pc wraps modulo 8192.
- rd and wr are never high in the same cycle. wr is a single-cycle pulse.
- Reset asserted mid-instruction (any state, including halted) aborts the instruction. No RAM write occurs in the reset cycle.

Test Plan:
- Reset: hold reset 2 cycles -> pc_addr=0, halt=0, rd=0, wr=0, fetch=1. After release, the first instruction is fetched from ROM[0], ROM[1]; pc_addr=2 by S2.
- LDA/STO: ROM = LDA 0x1800; STO 0x1801; HLT, with ram[0]=0x5A -> ram[1]=0x5A after 16 cycles; halt=1 at the third instruction's S3; pc frozen at 6.
- ALU wrap: ram[0]=0xFF, ram[1]=0x02, ram[2]=0x0F. Program: LDA 0x1800; ADD 0x1801; STO 0x1803; AND 0x1802; XOR 0x1802; STO 0x1804 -> ram[3]=0x01, ram[4]=0x0E.
- SKZ: acc=0 then SKZ; JMP 0x00A0; LDA... -> pc jumps from 4 to 6 and the JMP is skipped. With acc=1 the JMP is taken and pc_addr=0x00A0 at S5.
- Mid-instruction reset: assert reset during S6 of an STO -> wr never pulses, RAM unchanged, pc_addr=0 the next cycle.
- Fibonacci loop from ROM: ram[2] sequence 1,1,2,3,5,8,13,21,34,55,89,144,233; loop ends by HLT, and halt stays 1 until reset.

Source files
------------

// File: rtl/risc8_system.sv
// 8-bit accumulator CPU with on-chip program ROM and data RAM on one shared bus.
// Each instruction runs through eight states: two fetch cycles, decode, then execute.
module risc8_system (
  input  logic        clk,
  input  logic        reset,
  output logic        halt,
  output logic        rd,
  output logic        wr,
  output logic [12:0] addr,
  output logic [7:0]  data,
  output logic [2:0]  opcode,
  output logic        fetch,
  output logic [12:0] ir_addr,
  output logic [12:0] pc_addr
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } state_t;

  localparam logic [2:0] OpHlt = 3'd0;
  localparam logic [2:0] OpSkz = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpAnd = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpLda = 3'd5;
  localparam logic [2:0] OpSto = 3'd6;
  localparam logic [2:0] OpJmp = 3'd7;

  logic [7:0] memory [0:8191];
  logic [7:0] ram    [0:1023];

  state_t      state_q, state_d;
  logic [12:0] pc_q, pc_d;
  logic [7:0]  acc_q, acc_d;
  logic [15:0] ir_q, ir_d;
  logic        halt_q, halt_d;

  logic        ramSel;
  logic [7:0]  memRdata;
  logic [7:0]  aluResult;
  logic        aluOp;
  logic        isSto;
  logic        rdRaw, wrRaw, driveRaw, cpuDrive;

  assign opcode  = ir_q[15:13];
  assign ir_addr = ir_q[12:0];
  assign pc_addr = pc_q;
  assign halt    = halt_q;
  assign fetch   = ~state_q[2];
  assign addr    = fetch ? pc_q : ir_q[12:0];

  // The top 2K of the address space is RAM; the 1K array appears twice there.
  assign ramSel   = (addr[12:11] == 2'b11);
  assign memRdata = ramSel ? ram[addr[9:0]] : memory[addr];

  assign aluOp = (opcode == OpAdd) || (opcode == OpAnd) ||
                 (opcode == OpXor) || (opcode == OpLda);
  assign isSto = (opcode == OpSto);

  always_comb begin
    rdRaw    = 1'b0;
    wrRaw    = 1'b0;
    driveRaw = 1'b0;
    case (state_q)
      S0, S1: rdRaw = 1'b1;
      S4:     rdRaw = aluOp;
      S5: begin
        rdRaw    = aluOp;
        driveRaw = isSto;
      end
      S6: begin
        wrRaw    = isSto;
        driveRaw = isSto;
      end
      default: ;
    endcase
  end

  // Strobes are masked while reset is held so an aborted STO never reaches RAM.
  assign rd       = rdRaw & ~reset;
  assign wr       = wrRaw & ~reset;
  assign cpuDrive = driveRaw & ~reset;
  assign data     = rd ? memRdata : (cpuDrive ? acc_q : 8'hzz);

  always_comb begin
    case (opcode)
      OpAdd:   aluResult = acc_q + memRdata;
      OpAnd:   aluResult = acc_q & memRdata;
      OpXor:   aluResult = acc_q ^ memRdata;
      OpLda:   aluResult = memRdata;
      default: aluResult = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    halt_d  = halt_q;
    case (state_q)
      S0: begin
        ir_d[15:8] = memRdata;
        pc_d       = pc_q + 13'd1;
        state_d    = S1;
      end
      S1: begin
        ir_d[7:0] = memRdata;
        pc_d      = pc_q + 13'd1;
        state_d   = S2;
      end
      S2: state_d = S3;
      S3: begin
        // HLT parks the machine here; only reset gets it moving again.
        if (opcode == OpHlt) begin
          halt_d  = 1'b1;
          state_d = S3;
        end else begin
          state_d = S4;
        end
      end
      S4: begin
        if (opcode == OpJmp) pc_d = ir_q[12:0];
        state_d = S5;
      end
      S5: begin
        if (aluOp) acc_d = aluResult;
        state_d = S6;
      end
      S6: begin
        if ((opcode == OpSkz) && (acc_q == 8'd0)) pc_d = pc_q + 13'd2;
        state_d = S7;
      end
      default: state_d = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S0;
      pc_q    <= 13'd0;
      acc_q   <= 8'd0;
      ir_q    <= 16'd0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
      halt_q  <= halt_d;
    end
  end

  // RAM has no reset: its contents survive a CPU reset.
  always_ff @(posedge clk) begin
    if (wr && ramSel) ram[addr[9:0]] <= acc_q;
  end

endmodule

// File: tb/tb_risc8_system.sv
// Directed bench for risc8_system: preloads ROM/RAM, runs short programs and
// checks bus strobes, pc, halt and RAM results against hand-computed values.
module tb_risc8_system;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  wire         halt, rd, wr, fetch;
  wire  [12:0] addr, ir_addr, pc_addr;
  wire  [7:0]  data;
  wire  [2:0]  opcode;

  int checks = 0;
  int failures = 0;
  int fibIdx;
  int budget;

  logic [7:0] fib [13] = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21,
                           8'd34, 8'd55, 8'd89, 8'd144, 8'd233};

  always #5 clk = ~clk;

  risc8_system dut (
    .clk     (clk),
    .reset   (reset),
    .halt    (halt),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .data    (data),
    .opcode  (opcode),
    .fetch   (fetch),
    .ir_addr (ir_addr),
    .pc_addr (pc_addr)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clearMem;
    for (int i = 0; i < 8192; i++) dut.memory[i] = 8'h00;
    for (int i = 0; i < 1024; i++) dut.ram[i] = 8'h00;
  endtask

  task automatic loadInstr(input logic [12:0] at, input logic [15:0] word);
    dut.memory[at]         = word[15:8];
    dut.memory[at + 13'd1] = word[7:0];
  endtask

  task automatic runUntilHalt(input int limit);
    int n;
    n = 0;
    while (!halt && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Each program section: hold reset, load memories, release on a falling edge
  // so the cycle right after release is S0 of the first instruction.
  initial begin
    // ---- reset and LDA/STO/HLT ----
    reset = 1'b1;
    clearMem();
    loadInstr(13'd0, 16'hB800);
    loadInstr(13'd2, 16'hD801);
    loadInstr(13'd4, 16'h0000);
    dut.ram[0] = 8'h5A;
    applyStimulus(2);
    checkOutput("reset_pc", pc_addr, 16'd0);
    checkOutput("reset_halt", halt, 16'd0);
    checkOutput("reset_rd", rd, 16'd0);
    checkOutput("reset_wr", wr, 16'd0);
    checkOutput("reset_fetch", fetch, 16'd1);
    reset = 1'b0;
    #1;
    checkOutput("s0_rd", rd, 16'd1);
    checkOutput("s0_addr", addr, 16'd0);
    checkOutput("s0_data", data, 16'h00B8);
    applyStimulus(2);
    checkOutput("s2_pc", pc_addr, 16'd2);
    checkOutput("s2_opcode", opcode, 16'd5);
    checkOutput("s2_iraddr", ir_addr, 16'h1800);
    applyStimulus(12);
    checkOutput("sto_wr", wr, 16'd1);
    checkOutput("sto_rd", rd, 16'd0);
    checkOutput("sto_addr", addr, 16'h1801);
    checkOutput("sto_data", data, 16'h005A);
    applyStimulus(2);
    checkOutput("sto_ram1", dut.ram[1], 16'h005A);
    applyStimulus(4);
    checkOutput("hlt_halt", halt, 16'd1);
    checkOutput("hlt_pc", pc_addr, 16'd6);
    applyStimulus(10);
    checkOutput("hlt_hold_halt", halt, 16'd1);
    checkOutput("hlt_hold_pc", pc_addr, 16'd6);

    // ---- ALU wrap, RAM alias, ROM write ignored ----
    reset = 1'b1;
    clearMem();
    loadInstr(13'd0, 16'hB800);
    loadInstr(13'd2, 16'h5801);
    loadInstr(13'd4, 16'hD803);
    loadInstr(13'd6, 16'h7802);
    loadInstr(13'd8, 16'h9802);
    loadInstr(13'd10, 16'hDC04);
    loadInstr(13'd12, 16'hC001);
    loadInstr(13'd14, 16'h0000);
    dut.ram[0] = 8'hFF;
    dut.ram[1] = 8'h02;
    dut.ram[2] = 8'h0F;
    applyStimulus(2);
    reset = 1'b0;
    runUntilHalt(200);
    checkOutput("alu_halt", halt, 16'd1);
    checkOutput("alu_add_wrap", dut.ram[3], 16'h0001);
    checkOutput("alu_and_xor_alias", dut.ram[4], 16'h000E);
    checkOutput("alu_ram1_kept", dut.ram[1], 16'h0002);
    checkOutput("alu_rom_kept", dut.memory[1], 16'h0000);
    checkOutput("alu_pc", pc_addr, 16'd16);

    // ---- SKZ taken (acc==0) ----
    reset = 1'b1;
    clearMem();
    loadInstr(13'd0, 16'hB800);
    loadInstr(13'd2, 16'h2000);
    loadInstr(13'd4, 16'hE0A0);
    loadInstr(13'd6, 16'h0000);
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(15);
    checkOutput("skz_taken_pc", pc_addr, 16'd6);
    runUntilHalt(100);
    checkOutput("skz_taken_halt", halt, 16'd1);
    checkOutput("skz_taken_endpc", pc_addr, 16'd8);

    // ---- SKZ not taken (acc==1), JMP to 0x00A0 ----
    reset = 1'b1;
    dut.ram[0] = 8'h01;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(15);
    checkOutput("skz_nt_pc", pc_addr, 16'd4);
    applyStimulus(6);
    checkOutput("jmp_pc_s5", pc_addr, 16'h00A0);
    checkOutput("jmp_fetch_s5", fetch, 16'd0);
    runUntilHalt(100);
    checkOutput("jmp_halt", halt, 16'd1);
    checkOutput("jmp_endpc", pc_addr, 16'h00A2);

    // ---- reset during STO S6 ----
    reset = 1'b1;
    clearMem();
    loadInstr(13'd0, 16'hB800);
    loadInstr(13'd2, 16'hD801);
    loadInstr(13'd4, 16'h0000);
    dut.ram[0] = 8'h77;
    dut.ram[1] = 8'h33;
    applyStimulus(2);
    reset = 1'b0;
    applyStimulus(14);
    reset = 1'b1;
    #1;
    checkOutput("abort_wr_now", wr, 16'd0);
    applyStimulus(1);
    checkOutput("abort_pc", pc_addr, 16'd0);
    checkOutput("abort_wr", wr, 16'd0);
    checkOutput("abort_ram1", dut.ram[1], 16'h0033);
    reset = 1'b0;
    runUntilHalt(100);
    checkOutput("rerun_ram1", dut.ram[1], 16'h0077);

    // ---- Fibonacci loop ----
    reset = 1'b1;
    clearMem();
    loadInstr(13'd0, 16'hB800);
    loadInstr(13'd2, 16'h5801);
    loadInstr(13'd4, 16'hD802);
    loadInstr(13'd6, 16'hB801);
    loadInstr(13'd8, 16'hD800);
    loadInstr(13'd10, 16'hB802);
    loadInstr(13'd12, 16'hD801);
    loadInstr(13'd14, 16'h9803);
    loadInstr(13'd16, 16'h2000);
    loadInstr(13'd18, 16'hE000);
    loadInstr(13'd20, 16'h0000);
    dut.ram[0] = 8'd1;
    dut.ram[1] = 8'd0;
    dut.ram[3] = 8'hE9;
    applyStimulus(2);
    reset = 1'b0;
    fibIdx = 0;
    budget = 0;
    while (!halt && budget < 2000) begin
      @(negedge clk);
      budget++;
      if (wr && addr == 13'h1802) begin
        if (fibIdx < 13) checkOutput($sformatf("fib_%0d", fibIdx), data, {8'h00, fib[fibIdx]});
        fibIdx++;
      end
    end
    checkOutput("fib_count", fibIdx[15:0], 16'd13);
    checkOutput("fib_halt", halt, 16'd1);
    checkOutput("fib_last", dut.ram[2], 16'h00E9);
    applyStimulus(5);
    checkOutput("fib_halt_hold", halt, 16'd1);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("halted_reset_halt", halt, 16'd0);
    checkOutput("halted_reset_pc", pc_addr, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
